// File: rtl/butterfly_mul.sv
// butterfly_mul: sequential signed Q1.(n-1) multiplier for the FFT butterfly
// twiddle product. A radix-2 Booth engine retires one multiplier bit per cycle.
//
// Ports:
//   clock    - system clock, rising-edge active
//   n_reset  - asynchronous active-low reset
//   start    - request a multiply (sampled only while idle)
//   a, b     - signed Q1.(n-1) multiplicand / multiplier, captured on accept
//   busy     - high while an operation is in RUN or DONE
//   done     - one-cycle pulse, product/ovf valid
//   ovf      - product saturated (-1.0 * -1.0), held with product
//   product  - signed Q1.(n-1) truncated result, held until the next result
module butterfly_mul #(
  parameter int unsigned n = 8
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [n-1:0] product
);

  localparam int unsigned CntW = $clog2(n) + 1;
  localparam logic [n-1:0] MinVal = {1'b1, {(n-1){1'b0}}};
  localparam logic [n-1:0] MaxVal = {1'b0, {(n-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [n-1:0]    m_q, m_d;        // captured multiplicand
  logic [n:0]      acc_q, acc_d;    // upper half, one guard bit
  logic [n-1:0]    q_q, q_d;        // multiplier, shifts into lower product half
  logic            qm1_q, qm1_d;    // Booth q_-1 bit
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sat_q, sat_d;    // both operands were the most-negative value
  logic [n-1:0]    product_q, product_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [n:0]      m_ext;
  logic [n:0]      acc_sum;

  // State register and datapath flops.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= StIdle;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CntW'(n - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Booth add/subtract on the upper half.
  always_comb begin
    m_ext = {m_q[n-1], m_q};
    case ({q_q[0], qm1_q})
      2'b10:   acc_sum = acc_q - m_ext;
      2'b01:   acc_sum = acc_q + m_ext;
      default: acc_sum = acc_q;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d   = a;
          q_d   = b;
          qm1_d = 1'b0;
          acc_d = '0;
          cnt_d = '0;
          sat_d = (a == MinVal) && (b == MinVal);
        end
      end
      StRun: begin
        // Arithmetic shift right of {acc, q, q_-1}.
        acc_d = {acc_sum[n], acc_sum[n:1]};
        q_d   = {acc_sum[0], q_q[n-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + CntW'(1);
      end
      StDone: begin
        // Full 2n-bit product is {acc[n-1:0], q}; keep bits [2n-2:n-1].
        product_d = sat_q ? MaxVal : {acc_q[n-2:0], q_q[n-1]};
        ovf_d     = sat_q;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    busy    = (state_q != StIdle);
    done    = done_q;
    ovf     = ovf_q;
    product = product_q;
  end

endmodule

// File: tb/tb_butterfly_mul.sv
module tb_butterfly_mul;

  localparam int unsigned N = 8;

  logic         clock;
  logic         n_reset;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic         ovf;
  logic [N-1:0] product;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  butterfly_mul #(.n(N)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .product (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: floor(a*b / 2^7) with saturation of -1.0 * -1.0.
  function automatic logic [8:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    if (x == 8'h80 && y == 8'h80) return {1'b1, 8'h7F};
    p = int'($signed(x)) * int'($signed(y));
    p = p >>> 7;
    return {1'b0, p[7:0]};
  endfunction

  // Called in a cycle where the DUT is idle; returns one cycle after the accepting edge.
  task automatic start_op(input logic [7:0] aa, input logic [7:0] bb);
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    lat   = 1;
  endtask

  task automatic wait_done(input string tag, input logic [7:0] ep, input logic eo);
    logic [7:0] held;
    logic       stable;
    held   = product;
    stable = 1'b1;
    while (!done && lat < 30) begin
      @(posedge clock);
      #1;
      lat++;
      if (!done && product !== held) stable = 1'b0;
    end
    check({tag, " latency"}, lat, N + 2);
    check({tag, " product"}, product, ep);
    check({tag, " ovf"}, ovf, eo);
    check({tag, " stable"}, stable, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] ep, input logic eo);
    start_op(aa, bb);
    wait_done(tag, ep, eo);
  endtask

  initial begin
    int pulses;
    int first;
    int last;
    int changes;
    logic [8:0] r;
    logic [7:0] ra, rb;

    n_reset = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset ovf", ovf, 1'b0);
    check("reset product", product, 8'h00);
    @(negedge clock);
    n_reset = 1'b1;
    @(posedge clock);
    #1;

    // Basic and sign cases.
    start_op(8'h40, 8'h40);
    check("run busy", busy, 1'b1);
    wait_done("half_sq", 8'h20, 1'b0);
    run_op("half_neg", 8'h40, 8'hC0, 8'hE0, 1'b0);
    run_op("max_sq", 8'h7F, 8'h7F, 8'h7E, 1'b0);
    run_op("tiny_neg", 8'h01, 8'hFF, 8'hFF, 1'b0);
    run_op("zero", 8'h00, 8'h80, 8'h00, 1'b0);
    run_op("sat", 8'h80, 8'h80, 8'h7F, 1'b1);
    run_op("min_max", 8'h80, 8'h7F, 8'h81, 1'b0);

    // Start pulse during RUN must be ignored.
    start_op(8'h40, 8'h40);
    @(posedge clock); #1; lat++;
    a = 8'h10; b = 8'h10; start = 1'b1;
    @(posedge clock); #1; lat++;
    start = 1'b0;
    wait_done("ignore", 8'h20, 1'b0);
    run_op("pre_reset", 8'h40, 8'hC0, 8'hE0, 1'b0);

    // Reset three cycles into an operation.
    start_op(8'h40, 8'h40);
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_reset = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst ovf", ovf, 1'b0);
    check("midrst product", product, 8'h00);
    @(negedge clock);
    n_reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    check("midrst no done", pulses, 0);
    run_op("post_reset", 8'h40, 8'h40, 8'h20, 1'b0);

    // start held high: one result every N+2 cycles.
    a = 8'h7F; b = 8'h7F; start = 1'b1;
    pulses = 0; first = -1; last = -1; changes = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) begin
        pulses++;
        if (first < 0) first = i;
        else check("held interval", i - last, N + 2);
        last = i;
        check("held product", product, 8'h7E);
      end else if (first >= 0 && product !== 8'h7E) begin
        changes++;
      end
    end
    start = 1'b0;
    check("held pulses", pulses, 4);
    check("held first", first, N + 1);
    check("held stable", changes, 0);
    repeat (N + 3) @(posedge clock);
    #1;

    // Random operands against the reference.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      r  = ref_mul(ra, rb);
      run_op("random", ra, rb, r[7:0], r[8]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
